// File: rtl/cpu_defs.sv
// Shared CPU definitions: opcodes, store-entry layout and store lane formatting.
// The full store entry is {addr[AW-1:2], st_lane_t}; the address part depends on AW.
package cpu_defs;

  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SW  = 6'h2b;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_LUI = 6'h0f;

  typedef struct packed {
    logic [31:0] wdata;
    logic [3:0]  be;
  } st_lane_t;

  localparam int LANE_W = $bits(st_lane_t);

  typedef enum logic {
    DRAIN_IDLE,
    DRAIN_BUSY
  } drain_state_t;

  function automatic logic is_store_op(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SW);
  endfunction

  // A byte store is replicated to all lanes so memory only needs the byte enable.
  function automatic st_lane_t format_store(input logic [5:0]  op,
                                            input logic [1:0]  lane,
                                            input logic [31:0] data);
    st_lane_t f;
    if (op == OP_SB) begin
      f.wdata = {4{data[7:0]}};
      f.be    = 4'b0001 << lane;
    end else begin
      f.wdata = data;
      f.be    = 4'hf;
    end
    return f;
  endfunction

endpackage

// File: rtl/dm_store_unit_fifo.sv
// Register FIFO for the store buffer with count and per-entry valid/address taps
// so the top level can compare every pending entry against a load address.
module store_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 66,
  parameter int TAP_W = 30
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic                          pop,
  input  logic [WIDTH-1:0]              wr_data,
  output logic [WIDTH-1:0]              rd_data,
  output logic [$clog2(DEPTH):0]        count,
  output logic [DEPTH-1:0]              valid,
  output logic [DEPTH-1:0][TAP_W-1:0]   tap_addr
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // NOTE: the storage array has no reset; validity comes from count and the pointers,
  // and the top masks the head fields while nothing is pending.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];

  // Entry i is pending when its distance from the read pointer is below count.
  always_comb begin
    valid    = '0;
    tap_addr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid[i]    = {1'b0, PTR_W'(i) - rd_ptr} < count;
      tap_addr[i] = mem[i][WIDTH-1 -: TAP_W];
    end
  end

endmodule

// File: rtl/dm_store_unit.sv
// Store unit: formats sb/sw data into byte lanes, buffers stores and drains them to
// data memory over req/ack, and flags loads that alias a pending store word.
module dm_store_unit
  import cpu_defs::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          st_valid,
  input  logic [5:0]    st_op,
  input  logic [AW-1:0] st_addr,
  input  logic [31:0]   st_data,
  output logic          st_stall,
  input  logic          ld_check,
  input  logic [AW-1:0] ld_addr,
  output logic          ld_hit,
  output logic          dm_req,
  output logic [AW-1:0] dm_addr,
  output logic [31:0]   dm_wdata,
  output logic [3:0]    dm_be,
  input  logic          dm_ack,
  output logic          sb_empty
);

  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int WA_W    = AW - 2;
  localparam int ENTRY_W = WA_W + LANE_W;

  logic                       is_store;
  logic                       full;
  logic                       push;
  logic                       pop;
  st_lane_t                   lane_fmt;
  st_lane_t                   head_lane;
  logic [ENTRY_W-1:0]         wr_entry;
  logic [ENTRY_W-1:0]         head_entry;
  logic [WA_W-1:0]            head_waddr;
  logic [CNT_W-1:0]           count;
  logic [DEPTH-1:0]           valid;
  logic [DEPTH-1:0][WA_W-1:0] tap_addr;
  logic                       hit_any;
  logic                       ld_lane_unused;
  drain_state_t               state, state_nxt;

  assign is_store = is_store_op(st_op);
  assign full     = (count == CNT_W'(DEPTH));
  // A full buffer stalls even when the head pops this cycle; this keeps stall off the ack path.
  assign st_stall = full & st_valid & is_store;
  assign push     = st_valid & is_store & ~full;
  assign pop      = dm_req & dm_ack;
  assign sb_empty = (count == '0);

  assign lane_fmt = format_store(st_op, st_addr[1:0], st_data);
  assign wr_entry = {st_addr[AW-1:2], lane_fmt};

  store_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W),
    .TAP_W (WA_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (pop),
    .wr_data  (wr_entry),
    .rd_data  (head_entry),
    .count    (count),
    .valid    (valid),
    .tap_addr (tap_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= DRAIN_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    dm_req    = 1'b0;
    case (state)
      DRAIN_IDLE: begin
        if (push) state_nxt = DRAIN_BUSY;
      end
      DRAIN_BUSY: begin
        dm_req = 1'b1;
        if (pop && (count == CNT_W'(1)) && !push) state_nxt = DRAIN_IDLE;
      end
      default: state_nxt = DRAIN_IDLE;
    endcase
  end

  assign head_waddr = head_entry[ENTRY_W-1 -: WA_W];
  assign head_lane  = st_lane_t'(head_entry[LANE_W-1:0]);

  assign dm_addr  = dm_req ? {head_waddr, 2'b00} : '0;
  assign dm_wdata = dm_req ? head_lane.wdata     : '0;
  assign dm_be    = dm_req ? head_lane.be        : '0;

  // Word-granular compare; the entry popping this cycle is still valid and still hits.
  always_comb begin
    hit_any = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (tap_addr[i] == ld_addr[AW-1:2])) hit_any = 1'b1;
    end
  end

  assign ld_hit         = ld_check & hit_any;
  assign ld_lane_unused = ^ld_addr[1:0];

endmodule

// File: tb/tb_dm_store_unit.sv
// Directed bench for dm_store_unit: a per-cycle vector table plus hand-written
// sequences for full buffer, push/pop overlap, pointer wrap and async reset.
module tb_dm_store_unit;

  localparam logic [5:0] SB  = 6'h28;
  localparam logic [5:0] SW  = 6'h2b;
  localparam logic [5:0] LW  = 6'h23;
  localparam logic [5:0] NOP = 6'h00;

  logic        clk;
  logic        rst_n;
  logic        st_valid;
  logic [5:0]  st_op;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_stall;
  logic        ld_check;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic        dm_req;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_ack;
  logic        sb_empty;

  int checks = 0;
  int errors = 0;

  dm_store_unit #(.DEPTH(4), .AW(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .st_valid (st_valid),
    .st_op    (st_op),
    .st_addr  (st_addr),
    .st_data  (st_data),
    .st_stall (st_stall),
    .ld_check (ld_check),
    .ld_addr  (ld_addr),
    .ld_hit   (ld_hit),
    .dm_req   (dm_req),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_be    (dm_be),
    .dm_ack   (dm_ack),
    .sb_empty (sb_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sv;
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic        lc;
    logic [31:0] la;
    logic        ack;
    logic        stall;
    logic        hit;
    logic        req;
    logic [31:0] daddr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        empty;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic sv, input logic [5:0] op,
                              input logic [31:0] addr, input logic [31:0] data,
                              input logic lc, input logic [31:0] la, input logic ack,
                              input logic stall, input logic hit, input logic req,
                              input logic [31:0] daddr, input logic [31:0] wdata,
                              input logic [3:0] be, input logic empty);
    vec_t v;
    v.sv = sv; v.op = op; v.addr = addr; v.data = data;
    v.lc = lc; v.la = la; v.ack = ack;
    v.stall = stall; v.hit = hit; v.req = req;
    v.daddr = daddr; v.wdata = wdata; v.be = be; v.empty = empty;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input logic sv, input logic [5:0] op, input logic [31:0] addr,
                       input logic [31:0] data, input logic lc, input logic [31:0] la,
                       input logic ack);
    @(negedge clk);
    st_valid = sv; st_op = op; st_addr = addr; st_data = data;
    ld_check = lc; ld_addr = la; dm_ack = ack;
    #1;
  endtask

  task automatic idle(input logic ack);
    apply(1'b0, NOP, 32'h0, 32'h0, 1'b0, 32'h0, ack);
  endtask

  task automatic check_head(input string tag, input logic req, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] be);
    check({tag, ".req"},   64'(dm_req),   64'(req));
    check({tag, ".addr"},  64'(dm_addr),  64'(a));
    check({tag, ".wdata"}, 64'(dm_wdata), 64'(wd));
    check({tag, ".be"},    64'(dm_be),    64'(be));
  endtask

  initial begin
    rst_n = 1'b0;
    st_valid = 1'b0; st_op = NOP; st_addr = '0; st_data = '0;
    ld_check = 1'b0; ld_addr = '0; dm_ack = 1'b0;

    //              sv op   addr          data          lc la            ack stl hit req daddr         wdata         be     empty
    vecs.push_back(mk(0, NOP, 32'h0,        32'h0,        0, 32'h0,        0,  0,  0,  0,  32'h0,        32'h0,        4'h0,  1));
    vecs.push_back(mk(1, SW,  32'h100,      32'hDEADBEEF, 0, 32'h0,        1,  0,  0,  0,  32'h0,        32'h0,        4'h0,  1));
    vecs.push_back(mk(0, NOP, 32'h0,        32'h0,        0, 32'h0,        1,  0,  0,  1,  32'h100,      32'hDEADBEEF, 4'hf,  0));
    vecs.push_back(mk(0, NOP, 32'h0,        32'h0,        0, 32'h0,        1,  0,  0,  0,  32'h0,        32'h0,        4'h0,  1));
    vecs.push_back(mk(1, SB,  32'h103,      32'h000000A5, 0, 32'h0,        0,  0,  0,  0,  32'h0,        32'h0,        4'h0,  1));
    vecs.push_back(mk(0, NOP, 32'h0,        32'h0,        0, 32'h0,        1,  0,  0,  1,  32'h100,      32'hA5A5A5A5, 4'h8,  0));
    vecs.push_back(mk(0, NOP, 32'h0,        32'h0,        0, 32'h0,        1,  0,  0,  0,  32'h0,        32'h0,        4'h0,  1));
    vecs.push_back(mk(1, LW,  32'h300,      32'h1,        0, 32'h0,        1,  0,  0,  0,  32'h0,        32'h0,        4'h0,  1));
    vecs.push_back(mk(0, NOP, 32'h0,        32'h0,        0, 32'h0,        1,  0,  0,  0,  32'h0,        32'h0,        4'h0,  1));
    vecs.push_back(mk(1, SW,  32'h200,      32'h11223344, 1, 32'h200,      0,  0,  0,  0,  32'h0,        32'h0,        4'h0,  1));
    vecs.push_back(mk(0, NOP, 32'h0,        32'h0,        1, 32'h202,      0,  0,  1,  1,  32'h200,      32'h11223344, 4'hf,  0));
    vecs.push_back(mk(0, NOP, 32'h0,        32'h0,        1, 32'h204,      0,  0,  0,  1,  32'h200,      32'h11223344, 4'hf,  0));
    vecs.push_back(mk(0, NOP, 32'h0,        32'h0,        0, 32'h200,      0,  0,  0,  1,  32'h200,      32'h11223344, 4'hf,  0));
    vecs.push_back(mk(0, NOP, 32'h0,        32'h0,        1, 32'h200,      1,  0,  1,  1,  32'h200,      32'h11223344, 4'hf,  0));
    vecs.push_back(mk(0, NOP, 32'h0,        32'h0,        1, 32'h202,      0,  0,  0,  0,  32'h0,        32'h0,        4'h0,  1));
    vecs.push_back(mk(1, SB,  32'h204,      32'h12345677, 0, 32'h0,        0,  0,  0,  0,  32'h0,        32'h0,        4'h0,  1));
    vecs.push_back(mk(0, NOP, 32'h0,        32'h0,        0, 32'h0,        1,  0,  0,  1,  32'h204,      32'h77777777, 4'h1,  0));
    vecs.push_back(mk(1, SW,  32'h30A,      32'hCAFEF00D, 0, 32'h0,        0,  0,  0,  0,  32'h0,        32'h0,        4'h0,  1));
    vecs.push_back(mk(0, NOP, 32'h0,        32'h0,        0, 32'h0,        1,  0,  0,  1,  32'h308,      32'hCAFEF00D, 4'hf,  0));
    vecs.push_back(mk(1, SB,  32'h0FD,      32'hFFFFFF3C, 0, 32'h0,        0,  0,  0,  0,  32'h0,        32'h0,        4'h0,  1));
    vecs.push_back(mk(1, SB,  32'h0FE,      32'h0000005A, 0, 32'h0,        1,  0,  0,  1,  32'h0FC,      32'h3C3C3C3C, 4'h2,  0));
    vecs.push_back(mk(0, NOP, 32'h0,        32'h0,        0, 32'h0,        1,  0,  0,  1,  32'h0FC,      32'h5A5A5A5A, 4'h4,  0));
    vecs.push_back(mk(0, NOP, 32'h0,        32'h0,        0, 32'h0,        0,  0,  0,  0,  32'h0,        32'h0,        4'h0,  1));

    // Reset values while rst_n is held low.
    #3;
    check_head("reset", 1'b0, 32'h0, 32'h0, 4'h0);
    check("reset.empty", 64'(sb_empty), 64'd1);
    check("reset.stall", 64'(st_stall), 64'd0);
    check("reset.hit",   64'(ld_hit),   64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      apply(vecs[i].sv, vecs[i].op, vecs[i].addr, vecs[i].data,
            vecs[i].lc, vecs[i].la, vecs[i].ack);
      check_head($sformatf("v%0d", i), vecs[i].req, vecs[i].daddr, vecs[i].wdata, vecs[i].be);
      check($sformatf("v%0d.stall", i), 64'(st_stall), 64'(vecs[i].stall));
      check($sformatf("v%0d.hit", i),   64'(ld_hit),   64'(vecs[i].hit));
      check($sformatf("v%0d.empty", i), 64'(sb_empty), 64'(vecs[i].empty));
    end

    // Full buffer: four sw accepted with ack low, the fifth stalls and the head holds.
    for (int k = 0; k < 5; k++) begin
      apply(1'b1, SW, 32'h400 + 32'(4*k), 32'hA0 + 32'(k), 1'b0, 32'h0, 1'b0);
      check($sformatf("full%0d.stall", k), 64'(st_stall), 64'(k == 4));
      check_head($sformatf("full%0d", k), k != 0,
                 (k == 0) ? 32'h0 : 32'h400, (k == 0) ? 32'h0 : 32'hA0,
                 (k == 0) ? 4'h0 : 4'hf);
    end
    apply(1'b1, SW, 32'h500, 32'hFF, 1'b0, 32'h0, 1'b0);
    check("full.hold.stall", 64'(st_stall), 64'd1);
    apply(1'b1, SW, 32'h500, 32'hFF, 1'b0, 32'h0, 1'b1);
    check("full.pop.stall", 64'(st_stall), 64'd1);
    check_head("drain0", 1'b1, 32'h400, 32'hA0, 4'hf);
    for (int k = 1; k < 4; k++) begin
      idle(1'b1);
      check_head($sformatf("drain%0d", k), 1'b1, 32'h400 + 32'(4*k), 32'hA0 + 32'(k), 4'hf);
      check($sformatf("drain%0d.stall", k), 64'(st_stall), 64'd0);
    end
    idle(1'b0);
    check_head("drain.done", 1'b0, 32'h0, 32'h0, 4'h0);
    check("drain.empty", 64'(sb_empty), 64'd1);

    // Push and pop together at count 1: the new entry follows with no bubble.
    apply(1'b1, SW, 32'h600, 32'h600, 1'b0, 32'h0, 1'b0);
    apply(1'b1, SW, 32'h604, 32'h604, 1'b0, 32'h0, 1'b1);
    check_head("pp.first", 1'b1, 32'h600, 32'h600, 4'hf);
    check("pp.stall", 64'(st_stall), 64'd0);
    idle(1'b1);
    check_head("pp.second", 1'b1, 32'h604, 32'h604, 4'hf);
    check("pp.empty", 64'(sb_empty), 64'd0);
    idle(1'b0);
    check("pp.done", 64'(sb_empty), 64'd1);

    // Streaming at count 1 for 13 cycles walks both pointers through three wraps.
    for (int j = 0; j < 13; j++) begin
      apply(1'b1, SW, 32'h700 + 32'(4*j), 32'(j), 1'b0, 32'h0, 1'b1);
      check_head($sformatf("stream%0d", j), j != 0,
                 (j == 0) ? 32'h0 : 32'h700 + 32'(4*(j-1)),
                 (j == 0) ? 32'h0 : 32'(j-1), (j == 0) ? 4'h0 : 4'hf);
    end
    idle(1'b1);
    check_head("stream.last", 1'b1, 32'h730, 32'd12, 4'hf);

    // Fill/drain rounds with the pointers starting at an offset.
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 4; k++) begin
        apply(1'b1, SW, 32'h900 + 32'(16*r + 4*k), 32'(100*r + k), 1'b0, 32'h0, 1'b0);
        check($sformatf("round%0d.push%0d.stall", r, k), 64'(st_stall), 64'd0);
      end
      for (int k = 0; k < 4; k++) begin
        idle(1'b1);
        check_head($sformatf("round%0d.pop%0d", r, k), 1'b1,
                   32'h900 + 32'(16*r + 4*k), 32'(100*r + k), 4'hf);
      end
      idle(1'b0);
      check($sformatf("round%0d.empty", r), 64'(sb_empty), 64'd1);
    end

    // Asynchronous reset in the middle of a drain discards pending stores.
    for (int k = 0; k < 3; k++) apply(1'b1, SW, 32'h800 + 32'(4*k), 32'h80 + 32'(k), 1'b0, 32'h0, 1'b0);
    apply(1'b0, NOP, 32'h0, 32'h0, 1'b1, 32'h800, 1'b0);
    check_head("prerst", 1'b1, 32'h800, 32'h80, 4'hf);
    check("prerst.hit", 64'(ld_hit), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_head("rst", 1'b0, 32'h0, 32'h0, 4'h0);
    check("rst.empty", 64'(sb_empty), 64'd1);
    check("rst.hit",   64'(ld_hit),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(1'b1, SW, 32'h100, 32'hDEADBEEF, 1'b0, 32'h0, 1'b1);
    check("post.empty0", 64'(sb_empty), 64'd1);
    idle(1'b1);
    check_head("post", 1'b1, 32'h100, 32'hDEADBEEF, 4'hf);
    idle(1'b0);
    check("post.empty1", 64'(sb_empty), 64'd1);
    check("post.req", 64'(dm_req), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
